// File: rtl/ren_simd_arb.sv
// ---------------------------------------------------------------------------
// ren_simd_arb
//
// Purpose:
//   Arbitrates three requesters (0 = setup, 1 = interpolator, 2 = shader)
//   onto one shared FP_SIMD unit. At most one SIMD operation is in flight.
//   The winner's opcode and operands are latched at grant time, so a
//   requester may change or drop its inputs after the grant without
//   affecting the operation. The opcode is forwarded unchanged; no
//   arithmetic is done here.
//
// Optional feature:
//   REN_SIMD_ARB_LOCK_EN - when defined, a requester holding i_lock and
//   i_req in the S_DONE cycle wins the next grant regardless of rotation.
//   When undefined, i_lock is ignored and pure round-robin applies.
//
// Ports:
//   clk, rstn         clock; asynchronous active-high reset (1 = reset)
//   i_req[3]          per-requester request
//   i_opcode[3][3]    per-requester SIMD opcode
//   i_in0/i_in1[3][W] per-requester operand vectors, W = P_LANE_W*P_LANES
//   i_lock[3]         per-requester burst-lock request
//   o_gnt[3]          one-hot grant, held from S_ISSUE through S_DONE
//   o_rsp_valid[3]    one-cycle result strobe for the granted requester
//   o_rsp_data[W]     registered SIMD result, shared by all requesters
//   o_simd_*          request side of the FP_SIMD unit
//   i_simd_*          response side of the FP_SIMD unit
//   o_idle            high while in S_IDLE
//   o_dbg_state[2]    current FSM state encoding
//
// Handshake: o_simd_en is a one-cycle issue strobe that is only raised
// while i_simd_busy is low; i_simd_valid is accepted only in S_WAIT, and
// any i_simd_valid seen in another state is dropped.
// ---------------------------------------------------------------------------
module ren_simd_arb #(
    parameter int P_LANE_W = 22,
    parameter int P_LANES  = 4
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [2:0]                             i_req,
    input  logic [2:0][2:0]                        i_opcode,
    input  logic [2:0][P_LANE_W*P_LANES-1:0]       i_in0,
    input  logic [2:0][P_LANE_W*P_LANES-1:0]       i_in1,
    input  logic [2:0]                             i_lock,
    output logic [2:0]                             o_gnt,
    output logic [2:0]                             o_rsp_valid,
    output logic [P_LANE_W*P_LANES-1:0]            o_rsp_data,
    output logic                                   o_simd_en,
    output logic [2:0]                             o_simd_opcode,
    output logic [P_LANE_W*P_LANES-1:0]            o_simd_in0,
    output logic [P_LANE_W*P_LANES-1:0]            o_simd_in1,
    input  logic [P_LANE_W*P_LANES-1:0]            i_simd_out,
    input  logic                                   i_simd_valid,
    input  logic                                   i_simd_busy,
    output logic                                   o_idle,
    output logic [1:0]                             o_dbg_state
);

    localparam int W = P_LANE_W * P_LANES;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [2:0]   gnt_q,   gnt_d;
    logic [1:0]   win_q,   win_d;
    logic [1:0]   last_q,  last_d;
    logic [2:0]   op_q,    op_d;
    logic [W-1:0] in0_q,   in0_d;
    logic [W-1:0] in1_q,   in1_d;
    logic [W-1:0] data_q,  data_d;

    // Round-robin pick: scan (last+1), (last+2), (last+3) mod 3 and take
    // the first requester that is asking.
    logic [1:0] rr_win;
    logic [2:0] cand;
    logic       found;

    always_comb begin
        rr_win = 2'd0;
        cand   = 3'd0;
        found  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cand = {1'b0, last_q} + 3'(i);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!found && i_req[cand[1:0]]) begin
                found  = 1'b1;
                rr_win = cand[1:0];
            end
        end
    end

    // Lock: pointing r_last one behind the locked requester makes it the
    // first candidate of the next scan.
    logic       lock_hit;
    logic [1:0] win_prev;

    assign win_prev = (win_q == 2'd0) ? 2'd2 : (win_q - 2'd1);

`ifdef REN_SIMD_ARB_LOCK_EN
    assign lock_hit = i_lock[win_q] & i_req[win_q];
`else
    logic unused_lock;
    assign unused_lock = ^i_lock;
    assign lock_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        win_d   = win_q;
        last_d  = last_q;
        op_d    = op_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (|i_req) begin
                    win_d   = rr_win;
                    gnt_d   = 3'b001 << rr_win;
                    op_d    = i_opcode[rr_win];
                    in0_d   = i_in0[rr_win];
                    in1_d   = i_in1[rr_win];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!i_simd_busy) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_simd_valid) begin
                    data_d  = i_simd_out;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = lock_hit ? win_prev : win_q;
                gnt_d   = 3'b000;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= S_IDLE;
            gnt_q   <= 3'b000;
            win_q   <= 2'd0;
            last_q  <= 2'd2;
            op_q    <= 3'd0;
            in0_q   <= '0;
            in1_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            last_q  <= last_d;
            op_q    <= op_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            data_q  <= data_d;
        end
    end

    assign o_gnt         = gnt_q;
    assign o_rsp_valid   = (state_q == S_DONE) ? gnt_q : 3'b000;
    assign o_rsp_data    = data_q;
    assign o_simd_en     = (state_q == S_ISSUE) && !i_simd_busy;
    assign o_simd_opcode = op_q;
    assign o_simd_in0    = in0_q;
    assign o_simd_in1    = in1_q;
    assign o_idle        = (state_q == S_IDLE);
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_ren_simd_arb.sv
// Bench for ren_simd_arb: drives inputs on the falling edge, samples
// outputs 1 time unit later, and compares against a transaction-level
// model of the arbitration rules.
module tb_ren_simd_arb;
  localparam int LW = 22;
  localparam int NL = 4;
  localparam int W  = LW * NL;

`ifdef REN_SIMD_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rstn;
  logic [2:0]           i_req;
  logic [2:0][2:0]      i_opcode;
  logic [2:0][W-1:0]    i_in0;
  logic [2:0][W-1:0]    i_in1;
  logic [2:0]           i_lock;
  logic [2:0]           o_gnt;
  logic [2:0]           o_rsp_valid;
  logic [W-1:0]         o_rsp_data;
  logic                 o_simd_en;
  logic [2:0]           o_simd_opcode;
  logic [W-1:0]         o_simd_in0;
  logic [W-1:0]         o_simd_in1;
  logic [W-1:0]         i_simd_out;
  logic                 i_simd_valid;
  logic                 i_simd_busy;
  logic                 o_idle;
  logic [1:0]           o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state: last served requester, pending lock owner
  int m_last = 2;
  int m_lock = -1;

  logic [W-1:0] exp_q[$];

  ren_simd_arb #(.P_LANE_W(LW), .P_LANES(NL)) dut (
    .clk(clk), .rstn(rstn), .i_req(i_req), .i_opcode(i_opcode),
    .i_in0(i_in0), .i_in1(i_in1), .i_lock(i_lock), .o_gnt(o_gnt),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_simd_en(o_simd_en), .o_simd_opcode(o_simd_opcode),
    .o_simd_in0(o_simd_in0), .o_simd_in1(o_simd_in1),
    .i_simd_out(i_simd_out), .i_simd_valid(i_simd_valid),
    .i_simd_busy(i_simd_busy), .o_idle(o_idle), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom());
    return v;
  endfunction

  task automatic rand_operands();
    for (int k = 0; k < 3; k++) begin
      i_opcode[k] = 3'($urandom_range(0, 7));
      i_in0[k]    = rand_w();
      i_in1[k]    = rand_w();
    end
  endtask

  // reference model: pending lock owner first, else the first asking
  // requester in rotation after the last one served
  function automatic int model_pick(input logic [2:0] req);
    if (m_lock >= 0 && req[m_lock]) return m_lock;
    for (int i = 1; i <= 3; i++) begin
      if (req[(m_last + i) % 3]) return (m_last + i) % 3;
    end
    return -1;
  endfunction

  // One full operation. Called just after a falling edge in the S_IDLE
  // cycle with i_req already set; returns just after the falling edge of
  // the following S_IDLE cycle with i_req/i_lock = nreq/nlock.
  task automatic run_op(input int busy_n, input int lat, input bit drop,
                        input logic [W-1:0] dval,
                        input logic [2:0] nreq, input logic [2:0] nlock);
    int           w;
    logic [2:0]   oh;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    #1;
    check_eq("idle_flag", o_idle, 1'b1);
    check_eq("idle_gnt", o_gnt, 3'b000);
    check_eq("idle_rsp_valid", o_rsp_valid, 3'b000);
    w  = model_pick(i_req);
    oh = 3'(1 << w);
    op = i_opcode[w];
    a  = i_in0[w];
    b  = i_in1[w];
    i_simd_busy = (busy_n > 0);
    @(negedge clk);
    // S_ISSUE: scramble operands to prove they were latched
    rand_operands();
    for (int k = 0; k < busy_n; k++) begin
      i_simd_valid = 1'($urandom_range(0, 1));
      #1;
      check_eq("busy_en_low", o_simd_en, 1'b0);
      check_eq("issue_gnt", o_gnt, oh);
      check_eq("issue_rsp_valid", o_rsp_valid, 3'b000);
      @(negedge clk);
    end
    i_simd_valid = 1'b0;
    i_simd_busy  = 1'b0;
    #1;
    check_eq("issue_en", o_simd_en, 1'b1);
    check_eq("issue_gnt", o_gnt, oh);
    check_eq("issue_opcode", o_simd_opcode, op);
    check_eq("issue_in0", o_simd_in0, a);
    check_eq("issue_in1", o_simd_in1, b);
    if (drop) i_req[w] = 1'b0;
    @(negedge clk);
    // S_WAIT
    i_simd_busy = 1'($urandom_range(0, 1));
    for (int k = 1; k < lat; k++) begin
      #1;
      check_eq("wait_en_low", o_simd_en, 1'b0);
      check_eq("wait_rsp_valid", o_rsp_valid, 3'b000);
      check_eq("wait_gnt", o_gnt, oh);
      @(negedge clk);
    end
    i_simd_out   = dval;
    i_simd_valid = 1'b1;
    exp_q.push_back(dval);
    #1;
    check_eq("wait_en_low", o_simd_en, 1'b0);
    @(negedge clk);
    // S_DONE
    i_simd_valid = 1'b0;
    i_simd_busy  = 1'b0;
    i_simd_out   = rand_w();
    #1;
    check_eq("done_rsp_valid", o_rsp_valid, oh);
    check_eq("done_rsp_data", o_rsp_data, exp_q.pop_front());
    check_eq("done_gnt", o_gnt, oh);
    check_eq("done_en_low", o_simd_en, 1'b0);
    i_req  = nreq;
    i_lock = nlock;
    rand_operands();
    m_last = w;
    m_lock = (LOCK_EN && nlock[w] && nreq[w]) ? w : -1;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [2:0]   r, l;
    rstn = 1'b1;
    i_req = '0; i_opcode = '0; i_in0 = '0; i_in1 = '0; i_lock = '0;
    i_simd_out = '0; i_simd_valid = 1'b0; i_simd_busy = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_idle", o_idle, 1'b1);
    check_eq("rst_gnt", o_gnt, 3'b000);
    check_eq("rst_rsp_valid", o_rsp_valid, 3'b000);
    check_eq("rst_rsp_data", o_rsp_data, '0);
    check_eq("rst_simd_en", o_simd_en, 1'b0);
    check_eq("rst_simd_opcode", o_simd_opcode, 3'b000);
    check_eq("rst_simd_in0", o_simd_in0, '0);
    check_eq("rst_simd_in1", o_simd_in1, '0);
    @(negedge clk);
    rstn = 1'b0;

    // all three requesting: rotation 0, 1, 2, 0
    i_req = 3'b111;
    rand_operands();
    for (int k = 0; k < 4; k++) begin
      check_eq("rr_order", 32'(model_pick(i_req)), 32'(k % 3));
      run_op(0, 3, 1'b0, rand_w(), (k == 3) ? 3'b000 : 3'b111, 3'b000);
    end

    // requester 1 alone, mul, 0x1 in every lane
    ones = '0;
    for (int k = 0; k < NL; k++) ones = (ones << LW) | W'(1);
    i_req = 3'b010;
    i_opcode[1] = 3'd2;
    i_in0[1] = ones;
    i_in1[1] = ones;
    run_op(0, 3, 1'b0, W'(88'hABC), 3'b000, 3'b000);

    // SIMD busy for 5 cycles in S_ISSUE
    i_req = 3'b001;
    run_op(5, 2, 1'b0, rand_w(), 3'b000, 3'b000);

    // burst lock from requester 0 with requester 1 competing
    i_req  = 3'b011;
    i_lock = 3'b001;
    for (int k = 0; k < 4; k++) begin
      run_op(0, 2, 1'b0, rand_w(), (k == 3) ? 3'b000 : 3'b011, (k == 3) ? 3'b000 : 3'b001);
    end

    // requester 2 drops its request after grant
    i_req = 3'b100;
    run_op(1, 2, 1'b1, rand_w(), 3'b000, 3'b000);

    // randomized traffic
    r = 3'($urandom_range(1, 7));
    i_req = r;
    i_lock = 3'($urandom_range(0, 7));
    for (int k = 0; k < 40; k++) begin
      r = 3'($urandom_range(1, 7));
      l = 3'($urandom_range(0, 7));
      run_op($urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
             rand_w(), r, l);
    end
    i_req = 3'b000;
    i_lock = 3'b000;
    m_lock = -1;
    @(negedge clk);
    @(negedge clk);

    // reset during S_WAIT discards the result
    i_req = 3'b001;
    @(negedge clk);
    i_req = 3'b000;
    @(negedge clk);
    #1;
    check_eq("pre_rst_wait", o_idle, 1'b0);
    #1 rstn = 1'b1;
    #1;
    check_eq("mid_rst_idle", o_idle, 1'b1);
    check_eq("mid_rst_gnt", o_gnt, 3'b000);
    check_eq("mid_rst_rsp_valid", o_rsp_valid, 3'b000);
    check_eq("mid_rst_rsp_data", o_rsp_data, '0);
    check_eq("mid_rst_simd_en", o_simd_en, 1'b0);
    check_eq("mid_rst_opcode", o_simd_opcode, 3'b000);
    check_eq("mid_rst_in0", o_simd_in0, '0);
    check_eq("mid_rst_in1", o_simd_in1, '0);
    @(negedge clk);
    rstn = 1'b0;
    i_simd_valid = 1'b1;
    i_simd_out = rand_w();
    @(negedge clk);
    i_simd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("post_rst_rsp_valid", o_rsp_valid, 3'b000);
      check_eq("post_rst_idle", o_idle, 1'b1);
      check_eq("post_rst_data", o_rsp_data, '0);
      @(negedge clk);
    end
    m_last = 2;
    m_lock = -1;

    // after reset requester 0 is served first
    i_req = 3'b111;
    rand_operands();
    check_eq("post_rst_first", 32'(model_pick(i_req)), 32'd0);
    run_op(0, 1, 1'b0, rand_w(), 3'b000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
